// File: rtl/game_flow_ctrl.sv
// Round/stage sequencer downstream of bullet_collide: stage clear, game over, game won, hi-score.
// Optional pause sub-state compiled in with `define GAME_PAUSE_EN.
module game_flow_ctrl #(
  parameter int unsigned NUM_STAGES       = 8,
  parameter int unsigned PLAYER_LIVES     = 3,
  parameter int unsigned ENEMY_LIVES_BASE = 4,
  parameter int unsigned LOAD_CYCLES      = 4,
  parameter int unsigned CLEAR_WAIT       = 50000000,
  parameter int unsigned OVER_WAIT        = 100000000
) (
  input  logic        clk_i,
  input  logic        reset_all_i,
  input  logic        start_btn_i,
  input  logic        pause_btn_i,
  input  logic        two_player_i,
  input  logic [3:0]  player_1_live_left_i,
  input  logic [3:0]  player_2_live_left_i,
  input  logic [5:0]  enemy_left_i,
  input  logic        eagle_hit_i,
  input  logic [10:0] player_1_score_i,
  input  logic [10:0] player_2_score_i,
  output logic        round_reset_o,
  output logic [3:0]  player_lives_o,
  output logic [3:0]  enemy_lives_o,
  output logic [2:0]  state_o,
  output logic [3:0]  stage_o,
  output logic        freeze_o,
  output logic        game_over_o,
  output logic        game_won_o,
  output logic [10:0] hi_score_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PLAY  = 3'd2,
    S_CLEAR = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  localparam logic [3:0] ENEMY_RST = (ENEMY_LIVES_BASE > 15) ? 4'd15 : 4'(ENEMY_LIVES_BASE);

  state_t      state_q, state_d;
  logic [3:0]  stage_q, stage_d;
  logic [31:0] timer_q, timer_d;
  logic        tp_q, tp_d;
  logic [10:0] hi_q, hi_d;
  logic [10:0] p2_score_eff;
  logic [4:0]  enemy_sum;
  logic [3:0]  enemy_lives_q, enemy_lives_d;
  logic        round_reset_q, freeze_q, game_over_q, game_won_q;
  logic [2:0]  start_sync;
  logic        start_press, hold_play, play_live_d, all_dead;

  // [1] is the synchronized level, [2] its one-cycle delay for edge detect
  always_ff @(posedge clk_i or posedge reset_all_i) begin
    if (reset_all_i) start_sync <= '0;
    else             start_sync <= {start_sync[1:0], start_btn_i};
  end
  assign start_press = start_sync[1] & ~start_sync[2];

`ifdef GAME_PAUSE_EN
  logic [2:0] pause_sync;
  logic       pause_press, paused_q, paused_d;

  always_ff @(posedge clk_i or posedge reset_all_i) begin
    if (reset_all_i) begin
      pause_sync <= '0;
      paused_q   <= 1'b0;
    end else begin
      pause_sync <= {pause_sync[1:0], pause_btn_i};
      paused_q   <= paused_d;
    end
  end
  assign pause_press = pause_sync[1] & ~pause_sync[2];

  always_comb begin
    paused_d = paused_q;
    if (state_q == S_PLAY && pause_press) paused_d = ~paused_q;
    if (state_d != S_PLAY)                paused_d = 1'b0;
  end
  assign hold_play   = paused_q;
  assign play_live_d = (state_d == S_PLAY) && !paused_d;
`else
  logic unused_pause;
  assign unused_pause = pause_btn_i;
  assign hold_play    = 1'b0;
  assign play_live_d  = (state_d == S_PLAY);
`endif

  assign all_dead     = (player_1_live_left_i == 4'd0) && (!tp_q || player_2_live_left_i == 4'd0);
  assign p2_score_eff = tp_q ? player_2_score_i : 11'd0;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    tp_d    = tp_q;
    timer_d = timer_q;
    if (state_q == S_LOAD || state_q == S_CLEAR || state_q == S_OVER) timer_d = timer_q + 32'd1;
    case (state_q)
      S_IDLE: if (start_press) begin
        state_d = S_LOAD;
        stage_d = 4'd0;
        tp_d    = two_player_i;
      end
      S_LOAD: if (timer_q == 32'(LOAD_CYCLES - 1)) state_d = S_PLAY;
      S_PLAY: if (!hold_play) begin
        if (eagle_hit_i || all_dead)    state_d = S_OVER;
        else if (enemy_left_i == 6'd0)  state_d = S_CLEAR;
      end
      S_CLEAR: if (timer_q == 32'(CLEAR_WAIT - 1)) begin
        if (stage_q == 4'(NUM_STAGES - 1)) state_d = S_WIN;
        else begin
          state_d = S_LOAD;
          stage_d = stage_q + 4'd1;
        end
      end
      S_OVER: if (timer_q == 32'(OVER_WAIT - 1)) state_d = S_IDLE;
      S_WIN:  if (start_press) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;

    hi_d = hi_q;
    if (state_d != state_q && (state_d == S_OVER || state_d == S_WIN)) begin
      if (player_1_score_i > hi_d) hi_d = player_1_score_i;
      if (p2_score_eff > hi_d)     hi_d = p2_score_eff;
    end
  end

  // Widened so base + stage cannot wrap before saturation
  assign enemy_sum     = 5'(ENEMY_LIVES_BASE) + {1'b0, stage_d};
  assign enemy_lives_d = (enemy_sum > 5'd15) ? 4'd15 : enemy_sum[3:0];

  always_ff @(posedge clk_i or posedge reset_all_i) begin
    if (reset_all_i) begin
      state_q       <= S_IDLE;
      stage_q       <= '0;
      timer_q       <= '0;
      tp_q          <= 1'b0;
      hi_q          <= '0;
      enemy_lives_q <= ENEMY_RST;
      round_reset_q <= 1'b1;
      freeze_q      <= 1'b1;
      game_over_q   <= 1'b0;
      game_won_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      timer_q       <= timer_d;
      tp_q          <= tp_d;
      hi_q          <= hi_d;
      enemy_lives_q <= enemy_lives_d;
      round_reset_q <= (state_d == S_IDLE) || (state_d == S_LOAD);
      freeze_q      <= !play_live_d;
      game_over_q   <= (state_d == S_OVER);
      game_won_q    <= (state_d == S_WIN);
    end
  end

  assign state_o        = state_q;
  assign stage_o        = stage_q;
  assign hi_score_o     = hi_q;
  assign enemy_lives_o  = enemy_lives_q;
  assign player_lives_o = 4'(PLAYER_LIVES);
  assign round_reset_o  = round_reset_q;
  assign freeze_o       = freeze_q;
  assign game_over_o    = game_over_q;
  assign game_won_o     = game_won_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed game scenarios with randomized lives/enemy/score data, checked against a rule-level model.
module tb_game_flow_ctrl;

  localparam int unsigned NSTG = 2, CWAIT = 20, OWAIT = 30, LCYC = 4;

  logic        clk_i = 1'b0;
  logic        reset_all_i;
  logic        start_btn, pause_btn, two_player, eagle;
  logic [3:0]  p1l, p2l;
  logic [5:0]  enemy_left;
  logic [10:0] p1s, p2s;

  logic        rr, fr, go, gw;
  logic [3:0]  pl, el, stage;
  logic [2:0]  state;
  logic [10:0] hi;
  logic        d2_rr, d2_fr, d2_go, d2_gw;
  logic [3:0]  d2_pl, d2_el, d2_stage;
  logic [2:0]  d2_state;
  logic [10:0] d2_hi;

  always #5 clk_i = ~clk_i;

  game_flow_ctrl #(.NUM_STAGES(NSTG), .PLAYER_LIVES(3), .ENEMY_LIVES_BASE(4),
                   .LOAD_CYCLES(LCYC), .CLEAR_WAIT(CWAIT), .OVER_WAIT(OWAIT)) dut (
    .clk_i(clk_i), .reset_all_i(reset_all_i), .start_btn_i(start_btn), .pause_btn_i(pause_btn),
    .two_player_i(two_player), .player_1_live_left_i(p1l), .player_2_live_left_i(p2l),
    .enemy_left_i(enemy_left), .eagle_hit_i(eagle), .player_1_score_i(p1s), .player_2_score_i(p2s),
    .round_reset_o(rr), .player_lives_o(pl), .enemy_lives_o(el), .state_o(state), .stage_o(stage),
    .freeze_o(fr), .game_over_o(go), .game_won_o(gw), .hi_score_o(hi));

  game_flow_ctrl #(.NUM_STAGES(NSTG), .PLAYER_LIVES(3), .ENEMY_LIVES_BASE(14),
                   .LOAD_CYCLES(LCYC), .CLEAR_WAIT(CWAIT), .OVER_WAIT(OWAIT)) dut_sat (
    .clk_i(clk_i), .reset_all_i(reset_all_i), .start_btn_i(start_btn), .pause_btn_i(pause_btn),
    .two_player_i(two_player), .player_1_live_left_i(p1l), .player_2_live_left_i(p2l),
    .enemy_left_i(enemy_left), .eagle_hit_i(eagle), .player_1_score_i(p1s), .player_2_score_i(p2s),
    .round_reset_o(d2_rr), .player_lives_o(d2_pl), .enemy_lives_o(d2_el), .state_o(d2_state),
    .stage_o(d2_stage), .freeze_o(d2_fr), .game_over_o(d2_go), .game_won_o(d2_gw), .hi_score_o(d2_hi));

  int unsigned n_checks = 0, n_pass = 0;
  int unsigned hi_exp = 0;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned exp_enemy(input int unsigned base, input int unsigned stg);
    return (base + stg > 15) ? 15 : base + stg;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int k;
    k = 0;
    while (state !== s && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic rand_alive();
    p1l        = 4'($urandom_range(1, 15));
    p2l        = 4'($urandom_range(1, 15));
    enemy_left = 6'($urandom_range(1, 63));
  endtask

  // Holds bullet_collide inputs at stale zeros through LOAD; they must be ignored there.
  task automatic start_game(input logic tp);
    start_btn = 1'b0;
    repeat (3) step();
    two_player = tp; p1l = '0; p2l = '0; enemy_left = '0; eagle = 1'b0;
    start_btn = 1'b1;
    repeat (3) step();
    start_btn = 1'b0;
    chk("start_to_load", 32'(state), 32'd1);
    rand_alive();
    wait_state(3'd2, 10, "load_to_play");
  endtask

  task automatic run_clear_wait(input string tag);
    repeat (CWAIT - 1) step();
    chk(tag, 32'(state), 32'd3);
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_stage"}, 32'(stage), 32'd0);
    chk({tag, "_rr"}, 32'(rr), 32'd1);
    chk({tag, "_freeze"}, 32'(fr), 32'd1);
    chk({tag, "_over"}, 32'(go), 32'd0);
    chk({tag, "_won"}, 32'(gw), 32'd0);
    chk({tag, "_hi"}, 32'(hi), 32'd0);
    chk({tag, "_enemy"}, 32'(el), exp_enemy(4, 0));
    chk({tag, "_enemy_sat"}, 32'(d2_el), exp_enemy(14, 0));
    chk({tag, "_plives"}, 32'(pl), 32'd3);
  endtask

  initial begin
    reset_all_i = 1'b1;
    start_btn = 0; pause_btn = 0; two_player = 0; eagle = 0;
    p1l = 0; p2l = 0; enemy_left = 0; p1s = 0; p2s = 0;
    repeat (3) step();
    check_reset_vals("reset");
    reset_all_i = 1'b0;
    step();

    // Game 1: single player, start timing, LOAD length, stage clear, then WIN
    start_btn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 2) chk("press_latency_idle", 32'(state), 32'd0);
      if (i >= 3 && i <= 6) begin
        chk("load_state", 32'(state), 32'd1);
        chk("load_rr", 32'(rr), 32'd1);
      end
      if (i == 3) chk("load_enemy_valid", 32'(el), exp_enemy(4, 0));
      if (i == 6) rand_alive();
      if (i == 7) begin
        chk("play_state", 32'(state), 32'd2);
        chk("play_rr", 32'(rr), 32'd0);
        chk("play_freeze", 32'(fr), 32'd0);
        chk("play_enemy_lives", 32'(el), exp_enemy(4, 0));
      end
    end
    repeat (3) step();
    start_btn = 1'b0;
    p1s = 11'($urandom_range(0, 59));
    p2s = 11'($urandom_range(60, 119));
    for (int i = 0; i < int'($urandom_range(5, 15)); i++) begin
      p1l        = 4'($urandom_range(1, 15));
      p2l        = 4'($urandom_range(0, 15));
      enemy_left = 6'($urandom_range(1, 63));
      step();
      chk("play_hold", 32'(state), 32'd2);
    end
    enemy_left = 6'd0;
    step();
    chk("clear_entry", 32'(state), 32'd3);
    enemy_left = 6'($urandom_range(1, 63));
    run_clear_wait("clear_len_s0");
    chk("clear_to_load", 32'(state), 32'd1);
    chk("stage_adv", 32'(stage), 32'd1);
    chk("enemy_lives_s1", 32'(el), exp_enemy(4, 1));
    chk("enemy_lives_sat", 32'(d2_el), exp_enemy(14, 1));
    wait_state(3'd2, 10, "load_to_play_s1");
    enemy_left = 6'd0;
    step();
    chk("clear_entry_s1", 32'(state), 32'd3);
    run_clear_wait("clear_len_s1");
    hi_exp = umax(hi_exp, p1s);
    chk("win_state", 32'(state), 32'd5);
    chk("win_flag", 32'(gw), 32'd1);
    chk("win_hi_p1only", 32'(hi), hi_exp);
    start_btn = 1'b1;
    step(); step();
    chk("win_wait_press", 32'(state), 32'd5);
    step();
    start_btn = 1'b0;
    chk("win_to_idle", 32'(state), 32'd0);
    chk("idle_rr", 32'(rr), 32'd1);

    // Game 2: single player dies with player 2 lives still nonzero
    start_game(1'b0);
    p1s = 11'($urandom_range(0, 119));
    p2s = 11'($urandom_range(0, 119));
    p1l = 4'd0; p2l = 4'd3;
    step();
    hi_exp = umax(hi_exp, p1s);
    chk("sp_dead_over", 32'(state), 32'd4);
    chk("sp_game_over", 32'(go), 32'd1);
    chk("sp_hi", 32'(hi), hi_exp);
    start_btn = 1'b1;
    repeat (4) step();
    start_btn = 1'b0;
    repeat (OWAIT - 5) step();
    chk("over_ignores_start", 32'(state), 32'd4);
    step();
    chk("over_to_idle", 32'(state), 32'd0);
    chk("over_idle_rr", 32'(rr), 32'd1);
    repeat (5) step();
    chk("start_not_queued", 32'(state), 32'd0);

    // Game 3: two players, needs both dead
    start_game(1'b1);
    p1l = 4'd0;
    p2l = 4'($urandom_range(1, 15));
    repeat ($urandom_range(3, 8)) step();
    chk("tp_p2_alive", 32'(state), 32'd2);
    p1s = 11'($urandom_range(0, 119));
    p2s = 11'($urandom_range(0, 119));
    p2l = 4'd0;
    step();
    hi_exp = umax(hi_exp, umax(p1s, p2s));
    chk("tp_dead_over", 32'(state), 32'd4);
    chk("tp_hi", 32'(hi), hi_exp);
    wait_state(3'd0, OWAIT + 5, "tp_over_idle");

    // Game 4: eagle hit and last enemy in the same cycle
    start_game(1'b1);
    p1s = 11'd37; p2s = 11'd120;
    eagle = 1'b1; enemy_left = 6'd0;
    step();
    eagle = 1'b0;
    hi_exp = umax(hi_exp, 120);
    chk("eagle_over_wins", 32'(state), 32'd4);
    chk("eagle_hi", 32'(hi), hi_exp);
    repeat (OWAIT - 1) step();
    chk("over_len", 32'(state), 32'd4);
    step();
    chk("eagle_idle", 32'(state), 32'd0);
    chk("eagle_idle_rr", 32'(rr), 32'd1);

    // Game 5: optional pause, then asynchronous reset in the middle of CLEAR
    start_game(1'b0);
`ifdef GAME_PAUSE_EN
    pause_btn = 1'b1;
    repeat (3) step();
    chk("pause_freeze", 32'(fr), 32'd1);
    chk("pause_state", 32'(state), 32'd2);
    chk("pause_rr", 32'(rr), 32'd0);
    pause_btn = 1'b0; enemy_left = 6'd0;
    repeat (4) step();
    chk("pause_blocks_clear", 32'(state), 32'd2);
    pause_btn = 1'b1;
    repeat (3) step();
    pause_btn = 1'b0;
    chk("resume_state", 32'(state), 32'd2);
    chk("resume_freeze", 32'(fr), 32'd0);
    step();
`else
    enemy_left = 6'd0;
    step();
`endif
    chk("g5_clear", 32'(state), 32'd3);
    enemy_left = 6'($urandom_range(1, 63));
    run_clear_wait("g5_clear_len");
    wait_state(3'd2, 10, "g5_play_s1");
    enemy_left = 6'd0;
    step();
    repeat (5) step();
    chk("pre_reset_state", 32'(state), 32'd3);
    chk("pre_reset_stage", 32'(stage), 32'd1);
    #2;
    reset_all_i = 1'b1;
    #1;
    check_reset_vals("async_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level round/stage sequencer sitting directly downstream of bullet_collide. Consumes lives-left, enemies-left, eagle-hit and score outputs. Decides when a stage is cleared, when the game is over and when the game is won. Drives the round reset and the per-stage lives counts back into bullet_collide, plus status for the renderer.

Parameters:
- NUM_STAGES, 8: stages per game; stage index 0..NUM_STAGES-1, max 16.
- PLAYER_LIVES, 3: lives loaded per player per stage, 1..15.
- ENEMY_LIVES_BASE, 4: enemy lives at stage 0, 1..15.
- LOAD_CYCLES, 4: cycles round_reset_o stays high in LOAD, at least 1.
- CLEAR_WAIT, 50000000: cycles spent in CLEAR before advancing.
- OVER_WAIT, 100000000: cycles spent in OVER before returning to IDLE.

Ports:
- clk_i  in  1  system clock
- reset_all_i  in  1  asynchronous, active-high global reset
- start_btn_i  in  1  raw start button, asynchronous to clk_i
- pause_btn_i  in  1  raw pause button; used only with GAME_PAUSE_EN
- two_player_i  in  1  player 2 participates; sampled on IDLE->LOAD
- player_1_live_left_i  in  4  from bullet_collide
- player_2_live_left_i  in  4  from bullet_collide
- enemy_left_i  in  6  from bullet_collide
- eagle_hit_i  in  1  bullet_collide_eagle_o
- player_1_score_i  in  11  running score
- player_2_score_i  in  11  running score
- round_reset_o  out  1  drives bullet_collide reset_i
- player_lives_o  out  4  drives player_1/2_lives_i
- enemy_lives_o  out  4  drives enemy_1_lives_i
- state_o  out  3  IDLE=0 LOAD=1 PLAY=2 CLEAR=3 OVER=4 WIN=5
- stage_o  out  4  current stage index
- freeze_o  out  1  high = movement/firing disabled
- game_over_o  out  1  high while in OVER
- game_won_o  out  1  high while in WIN
- hi_score_o  out  11  best single-player score since reset_all_i

Behaviour:
- Reset (asynchronous, reset_all_i):
  - state IDLE, stage_o 0, round_reset_o 1, freeze_o 1.
  - game_over_o 0, game_won_o 0, hi_score_o 0, timer 0, two-player latch 0.
- Button conditioning:
  - start_btn_i and pause_btn_i each pass through a 2-flop synchronizer.
  - Each button's "press" is a single-cycle rising-edge pulse on the synchronized signal.
  - A press occurs 3 clk_i edges after the raw rise.
- Outputs registered:
  - player_lives_o = PLAYER_LIVES at all times.
  - enemy_lives_o = min(ENEMY_LIVES_BASE + stage_o, 15); compute in 5 bits, then saturate.
  - round_reset_o = 1 in IDLE and LOAD, 0 otherwise.
  - freeze_o = 1 in every state except PLAY.
  - Registered outputs update in the same cycle as the state register.
- FSM:
  - IDLE: start press -> LOAD. On that transition: stage_o <= 0, latch two_player_i, timer <= 0.
  - LOAD:
    - Timer counts 0..LOAD_CYCLES-1; at LOAD_CYCLES-1 -> PLAY, timer <= 0.
    - enemy_lives_o is already valid on LOAD entry, so bullet_collide samples correct lives while held in reset.
  - PLAY, evaluated every cycle, with priority:
    1. eagle_hit_i -> OVER.
    2. "all dead" -> OVER. All dead means player_1_live_left_i == 0 AND (two-player latch == 0 OR player_2_live_left_i == 0).
    3. enemy_left_i == 0 -> CLEAR.
    - When eagle hit / all dead and enemy_left_i == 0 occur in the same cycle, OVER wins.
  - CLEAR:
    - Timer counts to CLEAR_WAIT-1.
    - Then, if stage_o == NUM_STAGES-1 -> WIN.
    - Otherwise stage_o <= stage_o + 1 and -> LOAD, timer <= 0.
  - OVER:
    - Timer counts to OVER_WAIT-1, then -> IDLE.
    - Start presses during OVER are ignored, not queued.
  - WIN: start press -> IDLE.
- Hi-score:
  - On the cycle of entering OVER or WIN, hi_score_o <= max(hi_score_o, player_1_score_i, player_2_score_i).
  - Player 2's score counts only when the two-player latch is set.
  - Comparison is unsigned 11-bit. No other updates.
- Timer:
  - 32-bit, cleared on every state change.
  - Never wraps within a state, given the parameter limits.
- Inputs from bullet_collide are ignored outside PLAY; in particular stale zeros seen during LOAD are ignored.

Optional Feature:
- Macro GAME_PAUSE_EN.
- Defined:
  - Sub-state paused (1 bit, reset 0). A pause press in PLAY toggles it.
  - While paused: freeze_o 1, round_reset_o 0, state_o stays PLAY, and all PLAY exit conditions are suppressed.
  - Leaving PLAY for any reason clears paused.
- Undefined:
  - pause_btn_i is unused, with its synchronizer omitted.
  - freeze_o in PLAY is always 0.

Test Plan:
- Release reset, pulse start_btn_i for 10 cycles.
  - Required: state_o 0->1 three cycles after the press edge; round_reset_o high for exactly 4 cycles; then state_o=2 with freeze_o=0 and enemy_lives_o=4.
- In PLAY (stage 0), drive enemy_left_i=0.
  - Required: state_o=3 next cycle; after CLEAR_WAIT (bench uses 20), stage_o=1, state_o=1, enemy_lives_o=5.
- Single-player in PLAY: drive player_1_live_left_i=0, player_2_live_left_i=3.
  - Required: OVER next cycle and game_over_o=1.
  - Repeat with two-player latched: no transition until player_2_live_left_i=0 as well.
- In PLAY, assert eagle_hit_i and enemy_left_i=0 in the same cycle, with scores 37 and 120 (two-player).
  - Required: state_o=4, hi_score_o=120.
  - After OVER_WAIT (bench uses 30): IDLE, round_reset_o=1.
- Clear stage NUM_STAGES-1 (bench uses NUM_STAGES=2).
  - Required: state_o=5, game_won_o=1; a start press returns to IDLE.
  - Also with ENEMY_LIVES_BASE=14 at stage 1: enemy_lives_o=15 (saturated).
- Assert reset_all_i mid-CLEAR.
  - Required: all outputs at reset values immediately (asynchronous).
  - With GAME_PAUSE_EN: pause press in PLAY gives freeze_o=1 and blocks enemy_left_i=0; a second press resumes and CLEAR follows next cycle.
